dmem_access_arbiter: RTL and testbench
======================================

// Module: dmem_access_arbiter
// PURPOSE
//  Shares the single-port data memory between the MEM pipeline stage and a debug/loader port.
//  The pipeline has priority, but a saturating starvation counter guarantees the debug port a grant.
//  Reads have one-cycle latency; the arbiter routes each returned read word to the requester that issued it.
//  Sits between the EX/MEM pipeline register and the data memory array.
// PARAMETERS
//  DATA_W    8   data word width
//  ADDR_W    8   memory address width; upper request address bits are truncated
//  MAX_WAIT  4   debug cycles denied before forced grant (>=1)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       synchronous, active-high reset
//  pl_req     in   1       pipeline memory access this cycle (mem_en from EX)
//  pl_rw      in   1       1=write, 0=read
//  pl_addr    in   ADDR_W  pipeline address (ALU result)
//  pl_wdata   in   DATA_W  pipeline store data (bypassed B operand)
//  pl_rdata   out  DATA_W  pipeline load data
//  pl_stall   out  1       pipeline access not issued this cycle; hold MEM stage
//  dbg_req    in   1       debug request, held high until dbg_gnt
//  dbg_rw     in   1       1=write, 0=read
//  dbg_addr   in   ADDR_W  debug address
//  dbg_wdata  in   DATA_W  debug write data
//  dbg_gnt    out  1       1-cycle pulse: debug access issued this cycle
//  dbg_rdata  out  DATA_W  debug read data, valid with dbg_rvalid
//  dbg_rvalid out  1       1-cycle pulse, cycle after a granted debug read
//  mem_en     out  1       memory enable
//  mem_rw     out  1       memory 1=write, 0=read
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid 1 cycle after a read issue
// BEHAVIOUR
//  Reset: clk and reset only; reset is synchronous and active-high.
//   All state clears: owner=NONE, starve_cnt=0, pl_rdata hold=0, dbg_rvalid=0.
//   While reset is high: mem_en=0, pl_stall=0, dbg_gnt=0.
//  Grant (combinational, same cycle):
//   - debug wins if dbg_req && (!pl_req || starve_cnt==MAX_WAIT);
//   - else pipeline wins if pl_req;
//   - else none.
//  Issue: the winner's rw/addr/wdata drive mem_*, and mem_en=1.
//   No winner: mem_en=0 and mem_rw=0.
//  pl_stall = pl_req && debug wins. Combinational; no bubble is added when the pipeline wins.
//  dbg_gnt = debug wins. Requester drops dbg_req or presents the next access the following cycle.
//  starve_cnt (registered):
//   - +1 when dbg_req && !dbg_gnt, saturating at MAX_WAIT;
//   - cleared on dbg_gnt or when dbg_req=0.
//  FSM rd_owner (registered, records who issued a read last cycle):
//   - states NONE, PL_RD, DBG_RD;
//   - next = PL_RD if pipeline read issued, DBG_RD if debug read issued, else NONE.
//   - Writes always give NONE.
//  Read return:
//   - PL_RD: pl_rdata=mem_rdata this cycle and captured into the hold register.
//   - Otherwise pl_rdata = hold register.
//   - DBG_RD: dbg_rvalid=1 and dbg_rdata=mem_rdata; dbg_rdata is registered-held after.
//  Latency: read data arrives one cycle after the grant, for both ports.
//   Back-to-back reads from alternating owners are legal and route correctly.
//  Boundaries:
//   - Write-then-read to the same address on consecutive cycles returns the new data (memory-array property).
//   - Reset asserted while a read is outstanding: the return is discarded and dbg_rvalid stays 0.
//   - dbg_req dropped before grant: the request is abandoned and starve_cnt clears.
//  Widths: addresses truncated to ADDR_W. No arithmetic except starve_cnt, width clog2(MAX_WAIT+1).
// TESTING
//  1. Reset held 2 cycles with pl_req=1 and dbg_req=1
//     -> mem_en=0, pl_stall=0, dbg_gnt=0, dbg_rvalid=0, pl_rdata=0x00.
//  2. Pipeline write addr 0x05 data 0x50, then pipeline read 0x05
//     -> mem_en=1, mem_rw=1 on the write; pl_rdata=0x50 the cycle after the read; pl_stall stays 0.
//  3. Debug-only read 0x05 (pl_req=0)
//     -> dbg_gnt in the request cycle; next cycle dbg_rvalid=1, dbg_rdata=0x50.
//  4. pl_req held high continuously, dbg_req=1 write 0x1F<-0xAA
//     -> 4 denied cycles; dbg_gnt and pl_stall both 1 on the 5th cycle only; the memory then reads 0xAA at 0x1F.
//  5. Pipeline read 0x05 immediately followed by forced debug read 0x1F
//     -> pl_rdata=0x50, then dbg_rdata=0xAA with dbg_rvalid; no cross-routing.
//  6. Debug read granted, reset asserted the next cycle
//     -> dbg_rvalid=0, rd_owner=NONE, starve_cnt=0.

Source files
------------

// File: rtl/dmem_access_arbiter.sv
// ============================================================================
// dmem_access_arbiter: shares a single-port data memory between MEM stage and debug port
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_access_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pl_req_i,
    input  logic              pl_rw_i,
    input  logic [ADDR_W-1:0] pl_addr_i,
    input  logic [DATA_W-1:0] pl_wdata_i,
    output logic [DATA_W-1:0] pl_rdata_o,
    output logic              pl_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_rw_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_rvalid_o,
    output logic              mem_en_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  C_MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_PL_RD  = 2'd1,
        OWN_DBG_RD = 2'd2
    } owner_t;

    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [DATA_W-1:0]  pl_hold_q, pl_hold_d;
    logic [DATA_W-1:0]  dbg_hold_q, dbg_hold_d;

    logic w_dbg_win;
    logic w_pl_win;
    logic w_pl_ret;
    logic w_dbg_ret;

    // Reset suppresses every grant so no access reaches the memory while held.
    assign w_dbg_win = !reset && dbg_req_i && (!pl_req_i || (starve_q == C_MAX_CNT));
    assign w_pl_win  = !reset && pl_req_i && !w_dbg_win;
    assign w_pl_ret  = !reset && (owner_q == OWN_PL_RD);
    assign w_dbg_ret = !reset && (owner_q == OWN_DBG_RD);

    always_comb begin
        mem_en_o    = 1'b0;
        mem_rw_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_dbg_win) begin
            mem_en_o    = 1'b1;
            mem_rw_o    = dbg_rw_i;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
        end else if (w_pl_win) begin
            mem_en_o    = 1'b1;
            mem_rw_o    = pl_rw_i;
            mem_addr_o  = pl_addr_i;
            mem_wdata_o = pl_wdata_i;
        end
    end

    assign pl_stall_o   = pl_req_i && w_dbg_win;
    assign dbg_gnt_o    = w_dbg_win;
    assign dbg_rvalid_o = w_dbg_ret;
    assign pl_rdata_o   = w_pl_ret  ? mem_rdata_i : pl_hold_q;
    assign dbg_rdata_o  = w_dbg_ret ? mem_rdata_i : dbg_hold_q;

    always_comb begin
        owner_d    = OWN_NONE;
        starve_d   = starve_q;
        pl_hold_d  = pl_hold_q;
        dbg_hold_d = dbg_hold_q;

        if (w_dbg_win && !dbg_rw_i) begin
            owner_d = OWN_DBG_RD;
        end else if (w_pl_win && !pl_rw_i) begin
            owner_d = OWN_PL_RD;
        end

        if (!dbg_req_i || w_dbg_win) begin
            starve_d = '0;
        end else if (starve_q != C_MAX_CNT) begin
            starve_d = starve_q + CNT_W'(1);
        end

        if (w_pl_ret) begin
            pl_hold_d = mem_rdata_i;
        end
        if (w_dbg_ret) begin
            dbg_hold_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            pl_hold_q  <= '0;
            dbg_hold_q <= '0;
        end else begin
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            pl_hold_q  <= pl_hold_d;
            dbg_hold_q <= dbg_hold_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_arbiter.sv
// ============================================================================
// tb_dmem_access_arbiter: directed self-checking bench for dmem_access_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_access_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       pl_req, pl_rw;
    logic [7:0] pl_addr, pl_wdata, pl_rdata;
    logic       pl_stall;
    logic       dbg_req, dbg_rw;
    logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic       dbg_gnt, dbg_rvalid;
    logic       mem_en, mem_rw;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_access_arbiter #(
        .DATA_W  (8),
        .ADDR_W  (8),
        .MAX_WAIT(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pl_req_i    (pl_req),
        .pl_rw_i     (pl_rw),
        .pl_addr_i   (pl_addr),
        .pl_wdata_i  (pl_wdata),
        .pl_rdata_o  (pl_rdata),
        .pl_stall_o  (pl_stall),
        .dbg_req_i   (dbg_req),
        .dbg_rw_i    (dbg_rw),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_gnt_o   (dbg_gnt),
        .dbg_rdata_o (dbg_rdata),
        .dbg_rvalid_o(dbg_rvalid),
        .mem_en_o    (mem_en),
        .mem_rw_o    (mem_rw),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Single-port synchronous memory: read data appears the cycle after issue.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
        reset = 1'b1;
        pl_req = 1'b1; pl_rw = 1'b0; pl_addr = 8'h05; pl_wdata = 8'h00;
        dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 8'h05; dbg_wdata = 8'h00;

        // Reset held two edges with both requesters active
        tick();
        settle();
        chk("rst_mem_en",   {7'd0, mem_en},     8'h00);
        chk("rst_pl_stall", {7'd0, pl_stall},   8'h00);
        chk("rst_dbg_gnt",  {7'd0, dbg_gnt},    8'h00);
        chk("rst_rvalid",   {7'd0, dbg_rvalid}, 8'h00);
        chk("rst_pl_rdata", pl_rdata,           8'h00);
        tick();
        reset = 1'b0;

        // Pipeline write 0x05 <- 0x50
        pl_req = 1'b1; pl_rw = 1'b1; pl_addr = 8'h05; pl_wdata = 8'h50;
        dbg_req = 1'b0;
        settle();
        chk("plw_mem_en",  {7'd0, mem_en},   8'h01);
        chk("plw_mem_rw",  {7'd0, mem_rw},   8'h01);
        chk("plw_addr",    mem_addr,         8'h05);
        chk("plw_wdata",   mem_wdata,        8'h50);
        chk("plw_stall",   {7'd0, pl_stall}, 8'h00);
        tick();

        // Pipeline read 0x05
        pl_rw = 1'b0;
        settle();
        chk("plr_mem_rw",  {7'd0, mem_rw},   8'h00);
        chk("plr_stall",   {7'd0, pl_stall}, 8'h00);
        tick();
        pl_req = 1'b0;
        settle();
        chk("plr_rdata",   pl_rdata,         8'h50);
        chk("idle_mem_en", {7'd0, mem_en},   8'h00);
        tick();

        // Debug-only read 0x05
        dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 8'h05;
        settle();
        chk("dbgr_gnt",    {7'd0, dbg_gnt},  8'h01);
        chk("dbgr_stall",  {7'd0, pl_stall}, 8'h00);
        chk("dbgr_addr",   mem_addr,         8'h05);
        tick();
        dbg_req = 1'b0;
        settle();
        chk("dbgr_rvalid", {7'd0, dbg_rvalid}, 8'h01);
        chk("dbgr_rdata",  dbg_rdata,          8'h50);
        chk("dbgr_pl_hold", pl_rdata,          8'h50);
        tick();
        settle();
        chk("dbgr_rvalid_drop", {7'd0, dbg_rvalid}, 8'h00);
        chk("dbgr_rdata_hold",  dbg_rdata,          8'h50);
        tick();

        // Starved debug write 0x1F <- 0xAA against continuous pipeline reads
        pl_req = 1'b1; pl_rw = 1'b0; pl_addr = 8'h05;
        dbg_req = 1'b1; dbg_rw = 1'b1; dbg_addr = 8'h1F; dbg_wdata = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("starve_w_gnt%0d", i),   {7'd0, dbg_gnt},  8'h00);
            chk($sformatf("starve_w_stall%0d", i), {7'd0, pl_stall}, 8'h00);
            tick();
        end
        settle();
        chk("forced_w_gnt",   {7'd0, dbg_gnt},  8'h01);
        chk("forced_w_stall", {7'd0, pl_stall}, 8'h01);
        chk("forced_w_rw",    {7'd0, mem_rw},   8'h01);
        chk("forced_w_addr",  mem_addr,         8'h1F);
        chk("forced_w_wdata", mem_wdata,        8'hAA);
        chk("forced_w_plret", pl_rdata,         8'h50);
        tick();
        dbg_req = 1'b0;
        settle();
        chk("after_w_gnt",   {7'd0, dbg_gnt},  8'h00);
        chk("after_w_stall", {7'd0, pl_stall}, 8'h00);
        tick();

        // Pipeline read 0x05 immediately followed by forced debug read 0x1F
        dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 8'h1F;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("starve_r_gnt%0d", i), {7'd0, dbg_gnt}, 8'h00);
            tick();
        end
        settle();
        chk("forced_r_gnt",    {7'd0, dbg_gnt},    8'h01);
        chk("forced_r_pldata", pl_rdata,           8'h50);
        chk("forced_r_rvalid", {7'd0, dbg_rvalid}, 8'h00);
        tick();
        dbg_req = 1'b0; pl_req = 1'b0;
        settle();
        chk("ret_dbg_rvalid", {7'd0, dbg_rvalid}, 8'h01);
        chk("ret_dbg_rdata",  dbg_rdata,          8'hAA);
        chk("ret_pl_hold",    pl_rdata,           8'h50);
        tick();

        // Pipeline read of 0x1F sees the debug-written value
        pl_req = 1'b1; pl_rw = 1'b0; pl_addr = 8'h1F;
        settle();
        tick();
        pl_req = 1'b0;
        settle();
        chk("pl_1f_rdata",  pl_rdata,           8'hAA);
        chk("pl_1f_rvalid", {7'd0, dbg_rvalid}, 8'h00);
        tick();

        // Abandoned debug request clears the starvation count
        pl_req = 1'b1; pl_addr = 8'h05;
        dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 8'h05;
        tick();
        tick();
        tick();
        dbg_req = 1'b0;
        tick();
        dbg_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("abandon_gnt%0d", i), {7'd0, dbg_gnt}, 8'h00);
            tick();
        end
        settle();
        chk("abandon_forced_gnt", {7'd0, dbg_gnt}, 8'h01);
        tick();

        // Debug read granted, then reset while the return is outstanding
        pl_req = 1'b0;
        dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 8'h1F;
        settle();
        chk("rstrd_gnt", {7'd0, dbg_gnt}, 8'h01);
        tick();
        reset = 1'b1;
        settle();
        chk("rstrd_rvalid", {7'd0, dbg_rvalid}, 8'h00);
        chk("rstrd_gnt_rst", {7'd0, dbg_gnt},   8'h00);
        chk("rstrd_mem_en", {7'd0, mem_en},     8'h00);
        tick();
        reset = 1'b0;
        dbg_req = 1'b0;
        settle();
        chk("rstrd_rvalid_after", {7'd0, dbg_rvalid}, 8'h00);
        chk("rstrd_dbg_hold",     dbg_rdata,          8'h00);
        chk("rstrd_pl_hold",      pl_rdata,           8'h00);
        tick();

        // Starvation count restarted from zero after reset
        pl_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("post_rst_gnt%0d", i), {7'd0, dbg_gnt}, 8'h00);
            tick();
        end
        settle();
        chk("post_rst_forced", {7'd0, dbg_gnt}, 8'h01);
        tick();
        pl_req = 1'b0; dbg_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
